// File: rtl/prog_clk_div_if.sv
// prog_clk_div_if: control and status bundle of the programmable clock divider
interface prog_clk_div_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] div_active;
    logic             div_pending;
    logic             load_err;

    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, div_active, div_pending, load_err
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, div_active, div_pending, load_err
    );
endinterface

// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable even/odd clock divider with period tick
module prog_clk_div #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input logic         clk_in,
    input logic         reset,
    prog_clk_div_if.slave bus
);
    logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, pval_q, pval_d, half;
    logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d, err_q, err_d;
    logic             bnd, adv, load_ok;

    always_comb begin
        bnd     = cnt_q == act_q - 1'b1;
        adv     = bus.en && bnd;
        half    = act_q >> 1;
        load_ok = bus.div_load && (bus.div_val >= WIDTH'(2));
        cnt_d   = !bus.en ? cnt_q : bnd ? '0 : cnt_q + 1'b1;
        clk_d   = !bus.en ? clk_q : bnd || (cnt_q + 1'b1 < half);
        tick_d  = adv;
        // the boundary consumes the pending value seen before this edge
        act_d   = (adv && pend_q) ? pval_q : act_q;
        pval_d  = load_ok ? bus.div_val : pval_q;
        pend_d  = load_ok || (pend_q && !adv);
        err_d   = bus.div_load && !load_ok;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q  <= WIDTH'(DEFAULT_DIV - 1);
            act_q  <= WIDTH'(DEFAULT_DIV);
            pval_q <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pval_q <= pval_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign bus.clk_out     = clk_q;
    assign bus.tick        = tick_q;
    assign bus.div_active  = act_q;
    assign bus.div_pending = pend_q;
    assign bus.load_err    = err_q;
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed checks of prog_clk_div against hand-computed waveforms
module tb_prog_clk_div;
    logic clk_in = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #10 clk_in = ~clk_in;

    prog_clk_div_if #(.WIDTH(8)) bus ();

    prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic expect_wave(input string tag, input int n, input logic [63:0] cw, input logic [63:0] tw);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("%s_clk%0d", tag, i), 32'(bus.clk_out), 32'(cw[n-1-i]));
            chk($sformatf("%s_tick%0d", tag, i), 32'(bus.tick), 32'(tw[n-1-i]));
        end
    endtask

    task automatic load(input logic [7:0] v);
        bus.div_load = 1'b1;
        bus.div_val  = v;
        cyc();
        bus.div_load = 1'b0;
    endtask

    initial begin
        int highs, ticks, first_low;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.div_val = '0;
        bus.div_load = 1'b0;
        @(negedge clk_in);
        cyc();
        cyc();
        chk("rst_clk", 32'(bus.clk_out), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_active", 32'(bus.div_active), 4);
        chk("rst_pending", 32'(bus.div_pending), 0);
        chk("rst_err", 32'(bus.load_err), 0);

        reset = 1'b0;
        bus.en = 1'b1;
        expect_wave("def", 8, 8'b11001100, 8'b10001000);

        load(8'd1);
        chk("rej1_tick", 32'(bus.tick), 1);
        chk("rej1_err", 32'(bus.load_err), 1);
        chk("rej1_pending", 32'(bus.div_pending), 0);
        load(8'd0);
        chk("rej0_clk", 32'(bus.clk_out), 1);
        chk("rej0_err", 32'(bus.load_err), 1);
        chk("rej0_pending", 32'(bus.div_pending), 0);
        cyc();
        chk("rej_err_clear", 32'(bus.load_err), 0);
        chk("rej_clk", 32'(bus.clk_out), 0);
        cyc();
        chk("rej_active", 32'(bus.div_active), 4);

        cyc();
        chk("odd_b_tick", 32'(bus.tick), 1);
        load(8'd5);
        chk("odd_ld_clk", 32'(bus.clk_out), 1);
        chk("odd_ld_pending", 32'(bus.div_pending), 1);
        chk("odd_ld_active", 32'(bus.div_active), 4);
        expect_wave("inflight", 2, 2'b00, 2'b00);
        chk("inflight_pending", 32'(bus.div_pending), 1);
        expect_wave("odd", 10, 10'b1100011000, 10'b1000010000);
        chk("odd_active", 32'(bus.div_active), 5);
        chk("odd_pending", 32'(bus.div_pending), 0);

        cyc();
        chk("stall_b_tick", 32'(bus.tick), 1);
        bus.en = 1'b0;
        expect_wave("stall", 3, 3'b111, 3'b000);
        bus.en = 1'b1;
        expect_wave("resume", 4, 4'b1000, 4'b0000);

        cyc();
        chk("bl_b_tick", 32'(bus.tick), 1);
        load(8'd5);
        chk("bl_ld_clk", 32'(bus.clk_out), 1);
        expect_wave("bl_pre", 3, 3'b000, 3'b000);
        load(8'd6);
        chk("bl_tick", 32'(bus.tick), 1);
        chk("bl_active", 32'(bus.div_active), 5);
        chk("bl_pending", 32'(bus.div_pending), 1);
        expect_wave("n5", 4, 4'b1000, 4'b0000);
        cyc();
        chk("n6_tick", 32'(bus.tick), 1);
        chk("n6_active", 32'(bus.div_active), 6);
        chk("n6_pending", 32'(bus.div_pending), 0);
        expect_wave("n6", 11, 11'b11000111000, 11'b00000100000);

        load(8'd5);
        chk("mr_b_tick", 32'(bus.tick), 1);
        chk("mr_b_active", 32'(bus.div_active), 6);
        chk("mr_b_pending", 32'(bus.div_pending), 1);
        expect_wave("n6b", 5, 5'b11000, 5'b00000);
        cyc();
        chk("mr_n5_active", 32'(bus.div_active), 5);
        load(8'd7);
        cyc();
        chk("mr_low_clk", 32'(bus.clk_out), 0);
        chk("mr_low_pending", 32'(bus.div_pending), 1);
        reset = 1'b1;
        cyc();
        chk("mr_clk", 32'(bus.clk_out), 0);
        chk("mr_tick", 32'(bus.tick), 0);
        chk("mr_active", 32'(bus.div_active), 4);
        chk("mr_pending", 32'(bus.div_pending), 0);
        reset = 1'b0;
        expect_wave("post", 8, 8'b11001100, 8'b10001000);

        load(8'd2);
        chk("n2_b_tick", 32'(bus.tick), 1);
        chk("n2_b_active", 32'(bus.div_active), 4);
        expect_wave("pre2", 3, 3'b100, 3'b000);
        expect_wave("n2", 6, 6'b101010, 6'b101010);
        chk("n2_active", 32'(bus.div_active), 2);

        load(8'd255);
        chk("n255_ld_tick", 32'(bus.tick), 1);
        cyc();
        chk("n255_pre_clk", 32'(bus.clk_out), 0);
        cyc();
        chk("n255_b_tick", 32'(bus.tick), 1);
        chk("n255_b_clk", 32'(bus.clk_out), 1);
        chk("n255_active", 32'(bus.div_active), 255);
        highs = 0;
        ticks = 0;
        first_low = 0;
        for (int i = 1; i < 255; i++) begin
            cyc();
            if (bus.clk_out) highs++;
            if (bus.tick) ticks++;
            if (!bus.clk_out && first_low == 0) first_low = i;
        end
        chk("n255_highs", 32'(highs), 126);
        chk("n255_first_low", 32'(first_low), 127);
        chk("n255_ticks", 32'(ticks), 0);
        cyc();
        chk("n255_next_tick", 32'(bus.tick), 1);
        chk("n255_next_clk", 32'(bus.clk_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Parametrised, runtime-programmable clock divider. It is the successor to the fixed even divider and supports both even and odd ratios. The divisor can be reloaded glitch-free at period boundaries, and the block provides an enable and a one-cycle period tick. It sits in the clock/timing utilities and feeds slow-strobe consumers such as UART baud, LED blink and sampling logic, all within the clk_in domain.

Parameters:
WIDTH, 8, bit width of divisor and internal counter
DEFAULT_DIV, 4, divisor after reset; legal range 2 .. 2^WIDTH-1

Ports:
clk_in  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; 0 freezes divider state
div_val  input  WIDTH  requested divisor N
div_load  input  1  one-cycle strobe; captures div_val
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse, high in the cycle clk_out rises
div_active  output  WIDTH  divisor currently in effect
div_pending  output  1  a loaded divisor is waiting for the next boundary
load_err  output  1  one-cycle pulse: rejected load (div_val < 2)

Behaviour:
- Reset (sync, active-high, sampled on the clk_in rising edge), when reset=1:
  - cnt = DEFAULT_DIV-1; clk_out = 0; tick = 0
  - div_active = DEFAULT_DIV; pending register cleared; div_pending = 0; load_err = 0
- Reset has priority over en and div_load. Reset mid-period aborts the period immediately and discards any pending divisor.
- Phase split: N = div_active; H = floor(N/2) high cycles, N-H low cycles.
  - Even N gives 50% duty.
  - Odd N has the high phase one cycle shorter than the low phase (N=3: 1 high, 2 low).
- Each rising edge with en=1 and reset=0:
  - If cnt == N-1 (boundary):
    - cnt = 0; clk_out = 1; tick = 1.
    - If div_pending was 1 before this edge: div_active = pending value, div_pending = 0. H for the new period uses the new N.
  - Otherwise: cnt = cnt+1; clk_out = (cnt+1 < H); tick = 0.
- First enabled edge after reset is a boundary, so clk_out rises one cycle after reset deasserts (with en=1).
- en=0: cnt, clk_out and div_active are held; tick = 0. div_load is still accepted while en=0. Periods stretch by the number of disabled cycles.
- Load handling, when div_load=1:
  - div_val >= 2: pending = div_val; div_pending = 1 from the next cycle. A later load before the boundary overwrites it (latest wins).
  - div_val < 2: load_err = 1 for one cycle; pending state and div_active unchanged.
- Load on the same edge as a boundary: the boundary uses the pre-edge pending state. The new value becomes pending for the following boundary.
- A load equal to div_active is legal; it still sets div_pending and is applied at the boundary with no visible change.
- No combinational path from inputs to clk_out or tick. Output changes are glitch-free by construction (registered).
- Width rules: cnt is WIDTH bits and unsigned. The compare against N-1 never overflows because N <= 2^WIDTH-1.
- Max ratio is 2^WIDTH-1; for WIDTH=8, N=255 gives 127 high, 128 low.

Test Plan:
- Default ratio: reset 2 cycles, deassert, en=1, clk_in period 20 ns, WIDTH=8 -> clk_out high 2 / low 2 cycles, period 80 ns; tick once every 4 cycles, coincident with the clk_out rise; first rise 1 cycle after reset release.
- Odd reload: mid-period div_load with div_val=5 -> div_pending=1 until the next boundary; then div_active=5, clk_out 2 high / 3 low (100 ns period); the in-flight period completes at N=4.
- Rejected load: div_val=1 and div_val=0 strobes -> load_err pulses once each; div_active stays 4, div_pending stays 0, waveform unchanged.
- Enable stall and boundary load:
  - Drop en for 3 cycles during the high phase -> clk_out held high 3 extra cycles; no tick; cnt resumes.
  - Load 6 on the exact boundary edge while pending=5 -> 5 applied now, 6 applied at the next boundary.
- Reset mid-operation: assert reset during the low phase at N=5 with pending=7 -> next cycle clk_out=0, div_active=4, div_pending=0; after release, 4-cycle periods resume.
- Extremes: N=2 -> clk_out toggles every cycle, tick every 2 cycles; N=255 -> 127 high / 128 low, tick every 255 cycles.
